// File: rtl/keypad_pkg.sv
// Shared keypad scanner types: debouncer FSM states, per-frame key classes, code width helper.
// Pure declarations; no latency or backpressure of its own.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEBOUNCE_DN = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEBOUNCE_UP = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_class_e;

    function automatic int code_width(input int nkeys);
        return (nkeys <= 2) ? 1 : $clog2(nkeys);
    endfunction

endpackage

// File: rtl/keypad_frame_debouncer.sv
// Frame-rate press/release debouncer; emit_o is combinational with frame_done_i, no backpressure.
// KEYPAD_AUTOREPEAT_EN adds held-key repeat events after REPEAT_DELAY, then every REPEAT_RATE frames.
module keypad_frame_debouncer
    import keypad_pkg::*;
#(
    parameter int CW       = 4,
    parameter int DEBOUNCE = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          frame_done_i,
    input  frame_class_e  frame_class_i,
    input  logic [CW-1:0] frame_code_i,
    output logic          emit_o,
    output logic [CW-1:0] emit_code_o,
    output logic          held_o
);

    localparam logic [4:0] DEB = 5'(DEBOUNCE);

    kp_state_e     state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [CW-1:0] cand_q, cand_d;
    logic [4:0]    cnt_inc;
    logic          same_one;
    logic          fsm_emit;

    assign cnt_inc  = {1'b0, cnt_q} + 5'd1;
    assign same_one = (frame_class_i == FR_ONE) && (frame_code_i == cand_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        fsm_emit = 1'b0;
        if (frame_done_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_class_i == FR_ONE) begin
                        cand_d = frame_code_i;
                        cnt_d  = 4'd1;
                        if (DEBOUNCE == 1) begin
                            state_d  = ST_PRESSED;
                            fsm_emit = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE_DN;
                        end
                    end
                end
                ST_DEBOUNCE_DN: begin
                    if (!same_one) begin
                        state_d = ST_IDLE;
                    end else if (cnt_inc == DEB) begin
                        state_d  = ST_PRESSED;
                        fsm_emit = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[3:0];
                    end
                end
                ST_PRESSED: begin
                    if (frame_class_i == FR_NONE) begin
                        cnt_d   = 4'd1;
                        state_d = (DEBOUNCE == 1) ? ST_IDLE : ST_DEBOUNCE_UP;
                    end
                end
                ST_DEBOUNCE_UP: begin
                    if (frame_class_i != FR_NONE) begin
                        state_d = ST_PRESSED;
                    end else if (cnt_inc == DEB) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc[3:0];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [15:0] rpt_q, rpt_d;
    logic        rpt_armed_q, rpt_armed_d;
    logic        rpt_emit;

    // Counter only runs while the key stays in PRESSED across the frame edge.
    always_comb begin
        rpt_d       = rpt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_emit    = 1'b0;
        if (state_q != ST_PRESSED || state_d != ST_PRESSED) begin
            rpt_d       = '0;
            rpt_armed_d = 1'b0;
        end else if (frame_done_i) begin
            rpt_d = rpt_q + 16'd1;
            if (rpt_d == (rpt_armed_q ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY))) begin
                rpt_emit    = 1'b1;
                rpt_d       = '0;
                rpt_armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    assign emit_o = fsm_emit | rpt_emit;
`else
    assign emit_o = fsm_emit;
`endif

    assign emit_code_o = cand_d;
    assign held_o      = (state_q == ST_PRESSED) || (state_q == ST_DEBOUNCE_UP);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ROWS x COLS keypad scanner: press to key_valid in 2 sync + DEBOUNCE frames + 1 register cycle.
// One-entry valid/ready output; an event arriving while one is still pending is dropped and sets sticky overrun (KEYPAD_AUTOREPEAT_EN: repeats).
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    localparam int CW          = code_width(ROWS * COLS)
) (
    input  logic            clock_100Mhz,
    input  logic            reset,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CW-1:0]   key_code,
    output logic            key_held,
    output logic            multi_press,
    output logic            overrun
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);

    logic [COLS-1:0] col_s1_q, col_s2_q;
    logic [DW-1:0]   dwell_q;
    logic [RW-1:0]   row_q;
    logic [N-1:0]    frame_q, frame_now;
    logic            last_dwell, frame_done;
    logic [7:0]      ones;
    logic [CW-1:0]   frame_code;
    frame_class_e    frame_class;
    logic            emit;
    logic [CW-1:0]   emit_code;
    logic            vld_q, ovr_q, mp_q, accept;
    logic [CW-1:0]   code_q;

    assign last_dwell = (dwell_q == DW'(SCAN_DIV - 1));
    assign frame_done = last_dwell && (row_q == RW'(ROWS - 1));
    assign row_out    = ROWS'(1) << row_q;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            col_s1_q <= '0;
            col_s2_q <= '0;
            dwell_q  <= '0;
            row_q    <= '0;
            frame_q  <= '0;
        end else begin
            col_s1_q <= col_in;
            col_s2_q <= col_s1_q;
            dwell_q  <= last_dwell ? '0 : dwell_q + DW'(1);
            if (last_dwell) begin
                row_q   <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                frame_q <= frame_now;
            end
        end
    end

    // The current row's sample is merged in so the last row is classified on the same edge it is taken.
    always_comb begin
        frame_now = frame_q;
        frame_now[int'(row_q) * COLS +: COLS] = col_s2_q;
    end

    always_comb begin
        ones       = '0;
        frame_code = '0;
        for (int i = 0; i < N; i++) begin
            if (frame_now[i]) begin
                ones       = ones + 8'd1;
                frame_code = CW'(i);
            end
        end
    end

    assign frame_class = (ones == 8'd0) ? FR_NONE : (ones == 8'd1) ? FR_ONE : FR_MULTI;

    keypad_frame_debouncer #(
        .CW           (CW),
        .DEBOUNCE     (DEBOUNCE)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_debouncer (
        .clk_i         (clock_100Mhz),
        .rst_i         (reset),
        .frame_done_i  (frame_done),
        .frame_class_i (frame_class),
        .frame_code_i  (frame_code),
        .emit_o        (emit),
        .emit_code_o   (emit_code),
        .held_o        (key_held)
    );

    assign accept = vld_q && key_ready;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            code_q <= '0;
            ovr_q  <= 1'b0;
            mp_q   <= 1'b0;
        end else begin
            if (frame_done) begin
                mp_q <= (frame_class == FR_MULTI);
            end
            if (emit) begin
                if (!vld_q || accept) begin
                    vld_q  <= 1'b1;
                    code_q <= emit_code;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (accept) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign key_valid   = vld_q;
    assign key_code    = code_q;
    assign multi_press = mp_q;
    assign overrun     = ovr_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner for the guessing-game front end: drives one-hot rows, samples columns, debounces across full scan frames and delivers one key code per press over a valid/ready handshake. It sits between the board keypad pins and the game FSM/display logic, replacing fixed 4x4 row/column handling with a generic ROWS x COLS controller. Adds multi-press rejection and overrun flagging.

## Interface
- ROWS, 4, keypad rows driven (2..8)
- COLS, 4, keypad columns sensed (2..8)
- SCAN_DIV, 100000, clocks each row is held active (1 ms at 100 MHz); min 4
- DEBOUNCE, 4, consecutive identical frames required to accept press or release (1..15)
- REPEAT_DELAY, 50, frames before first auto-repeat (only with macro)
- REPEAT_RATE, 10, frames between repeats (only with macro)
- clock_100Mhz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- col_in  in  COLS  column sense lines, active-high, asynchronous to clock
- row_out  out  ROWS  one-hot row drive
- key_valid  out  1  key_code holds an unconsumed event
- key_ready  in  1  consumer accepts event when key_valid & key_ready at clock edge
- key_code  out  CW  row*COLS+col, CW = clog2(ROWS*COLS)
- key_held  out  1  debounced key currently down
- multi_press  out  1  last completed frame had >1 key
- overrun  out  1  sticky; event lost because key_valid was still pending

## Operation
- col_in passes a 2-flop synchroniser; all logic uses synchronised value.
- Dwell counter 0..SCAN_DIV-1; row index 0..ROWS-1 advances when counter wraps, wraps ROWS-1 -> 0.
- Columns sampled on the last dwell cycle of each row into frame bits [row*COLS +: COLS]; frame completes on last dwell cycle of row ROWS-1.
- Frame classification: NONE (0 bits), ONE (exactly 1, code = index), MULTI (>1). multi_press updated per frame.
- FSM states IDLE, DEBOUNCE_DN, PRESSED, DEBOUNCE_UP; transitions evaluated only at frame completion:
  - IDLE: ONE -> DEBOUNCE_DN, cnt=1, cand=code. NONE/MULTI stay.
  - DEBOUNCE_DN: ONE with same cand -> cnt+1; at cnt==DEBOUNCE -> PRESSED, emit event. Different code/NONE/MULTI -> IDLE.
  - PRESSED: NONE -> DEBOUNCE_UP cnt=1; ONE same/MULTI stay.
  - DEBOUNCE_UP: NONE -> cnt+1; cnt==DEBOUNCE -> IDLE. Anything else -> PRESSED.
  - DEBOUNCE=1: press accepted on first ONE frame (DEBOUNCE_DN skipped).
- key_held = state is PRESSED or DEBOUNCE_UP.
- Emit: if key_valid low, load key_code, set key_valid. If key_valid high and not accepted same cycle, event dropped, key_code unchanged, overrun set. Emit coinciding with acceptance loads new event (key_valid stays high).
- overrun clears only on reset.

## Timing
- Reset values: row_out = 1 (row 0), key_valid 0, key_code 0, key_held 0, multi_press 0, overrun 0, state IDLE, counters 0.
- key_valid rises the cycle after the frame-completion edge that reaches DEBOUNCE; key_valid falls the cycle after acceptance.
- Press-to-valid latency: between (DEBOUNCE-1)*ROWS*SCAN_DIV+3 and DEBOUNCE*ROWS*SCAN_DIV+3 cycles (2 sync + 1 register).
- Reset mid-scan or mid-handshake: immediate return to reset values; pending event discarded.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined: in PRESSED, frame counter emits repeat events for the held code after REPEAT_DELAY frames, then every REPEAT_RATE frames; repeats obey the same overrun rule; counter clears on leaving PRESSED.
- Undefined: exactly one event per press; REPEAT_* parameters ignored, no repeat counter logic synthesised.

## Structure
- Package keypad_pkg: FSM state enum, frame-class enum (NONE/ONE/MULTI), CW width function.
- Sub-module keypad_frame_debouncer: takes completed frame + class, owns FSM, count and repeat counter, outputs emit pulse and code; top keeps scan counters, synchroniser, handshake register.

## Test plan
Bench parameters ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=2 (frame = 32 cycles).
- Reset then idle 200 cycles -> row_out cycles 0001,0010,0100,1000 each 8 cycles; key_valid stays 0.
- Hold col_in=0100 while row_out=0010, key_ready=1 -> single key_valid pulse, key_code=6, within 67 cycles of first press sample; key_held 1.
- Bounce: press row 3 col 0 for one frame only -> no key_valid; state returns IDLE.
- Press codes 6 and 9 simultaneously -> multi_press=1, no event; release 9 -> code 6 accepted after 2 frames.
- key_ready=0, press/release code 1 then code 2 -> key_valid holds code 1, overrun=1; set key_ready -> code 1 accepted, key_valid drops.
- Assert reset while key_valid pending -> key_valid 0, row_out 0001 next edge; with KEYPAD_AUTOREPEAT_EN and REPEAT_DELAY=3, REPEAT_RATE=2, hold key -> repeats at frames 3,5,7 after acceptance.
